cordic_sweep_sequencer: RTL and testbench

Synthesizable, parametrised stimulus and capture sequencer for the CORDIC pipeline. It replaces the free-running degree ramp with a bounded, restartable sweep. It drives the pipeline inputs in rotate or arctan mode with a programmable start, step and sample count. It tags each issued sample, realigns the pipeline outputs with a configurable-latency valid shift register, and signals completion with busy/done, so that sweeps can run on-chip or under a bench without free-running timing assumptions.

---
 rtl/cordic_sweep_sequencer.sv | 174 +++++++++++++++++
 tb/tb_cordic_sweep_sequencer.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_sweep_sequencer.sv
// Bounded rotate/arctan sweep sequencer for the CORDIC pipeline: issues one sample per
// cycle, realigns pipeline results with a valid shift register and signals busy/done.
module cordic_sweep_sequencer #(
    parameter int WIDTH             = 16,
    parameter int SECTOR_FLAG_WIDTH = 2,
    parameter int PIPE_LATENCY      = 7,
    parameter int COUNT_WIDTH       = 12
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         mode,
    input  logic [WIDTH-1:0]             start_val,
    input  logic [WIDTH-1:0]             step,
    input  logic [COUNT_WIDTH-1:0]       count,
    input  logic [WIDTH-1:0]             x_const,
    input  logic [WIDTH-1:0]             y_const,
    output logic                         busy,
    output logic                         done,
    output logic [WIDTH-1:0]             degree_in,
    output logic [WIDTH-1:0]             x_in,
    output logic [WIDTH-1:0]             y_in,
    output logic [SECTOR_FLAG_WIDTH-1:0] sector_in,
    output logic                         arctan_en_in,
    input  logic [WIDTH-1:0]             degree_out,
    input  logic [WIDTH-1:0]             x_out,
    input  logic [WIDTH-1:0]             y_out,
    output logic                         cap_valid,
    output logic [COUNT_WIDTH-1:0]       cap_index,
    output logic [WIDTH-1:0]             cap_degree,
    output logic [WIDTH-1:0]             cap_x,
    output logic [WIDTH-1:0]             cap_y
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                         r_state;
    logic                           r_mode;
    logic [WIDTH-1:0]               r_step, r_acc, r_x, r_y;
    logic [COUNT_WIDTH-1:0]         r_count, r_issued, r_cap_cnt;
    logic                           r_busy, r_done, r_issue_valid;
    logic [PIPE_LATENCY-1:0]        r_vsr;
    logic [WIDTH-1:0]               r_degree_in, r_x_in, r_y_in;
    logic [SECTOR_FLAG_WIDTH-1:0]   r_sector_in;
    logic                           r_arctan_en;
    logic                           r_cap_valid;
    logic [COUNT_WIDTH-1:0]         r_cap_index;
    logic [WIDTH-1:0]               r_cap_degree, r_cap_x, r_cap_y;

    logic                           w_accept, w_issue, w_tail, w_mode;
    logic [WIDTH-1:0]               w_acc, w_step, w_x, w_y, w_degree, w_y_sample;
    logic [SECTOR_FLAG_WIDTH-1:0]   w_sector;

    always_comb begin
        w_accept   = (r_state == S_IDLE) && start;
        w_issue    = (w_accept && (count != '0)) || (r_state == S_RUN);
        w_tail     = r_vsr[PIPE_LATENCY-1];
        // Sample 0 comes straight from the ports on the accepting edge; later ones from latched operands.
        w_acc      = w_accept ? start_val : r_acc;
        w_step     = w_accept ? step      : r_step;
        w_mode     = w_accept ? mode      : r_mode;
        w_x        = w_accept ? x_const   : r_x;
        w_y        = w_accept ? y_const   : r_y;
        w_degree   = w_acc;
        w_y_sample = w_y;
        w_sector   = w_acc[WIDTH-1 -: SECTOR_FLAG_WIDTH];
        if (w_mode) begin
            w_degree   = '0;
            w_y_sample = w_acc;
            w_sector   = '0;
        end
    end

    // NOTE: every register here uses non-blocking assignment so all of them sample pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_mode        <= 1'b0;
            r_step        <= '0;
            r_acc         <= '0;
            r_x           <= '0;
            r_y           <= '0;
            r_count       <= '0;
            r_issued      <= '0;
            r_cap_cnt     <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_issue_valid <= 1'b0;
            r_vsr         <= '0;
            r_degree_in   <= '0;
            r_x_in        <= '0;
            r_y_in        <= '0;
            r_sector_in   <= '0;
            r_arctan_en   <= 1'b0;
            r_cap_valid   <= 1'b0;
            r_cap_index   <= '0;
            r_cap_degree  <= '0;
            r_cap_x       <= '0;
            r_cap_y       <= '0;
        end else begin
            r_done        <= 1'b0;
            r_issue_valid <= w_issue;
            r_vsr         <= (r_vsr << 1) | PIPE_LATENCY'(r_issue_valid);
            r_cap_valid   <= w_tail;

            if (w_tail) begin
                r_cap_degree <= degree_out;
                r_cap_x      <= x_out;
                r_cap_y      <= y_out;
                r_cap_index  <= r_cap_cnt;
                r_cap_cnt    <= r_cap_cnt + COUNT_WIDTH'(1);
            end

            if (w_issue) begin
                r_degree_in <= w_degree;
                r_x_in      <= w_x;
                r_y_in      <= w_y_sample;
                r_sector_in <= w_sector;
                r_arctan_en <= w_mode;
                r_acc       <= w_acc + w_step;
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mode      <= mode;
                        r_step      <= step;
                        r_count     <= count;
                        r_x         <= x_const;
                        r_y         <= y_const;
                        r_cap_cnt   <= '0;
                        r_cap_index <= '0;
                        r_issued    <= COUNT_WIDTH'(1);
                        if (count == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_busy  <= 1'b1;
                            r_state <= (count == COUNT_WIDTH'(1)) ? S_DRAIN : S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    r_issued <= r_issued + COUNT_WIDTH'(1);
                    if (r_issued == r_count - COUNT_WIDTH'(1)) r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    // Finish only once the last capture has been presented on cap_valid.
                    if ((r_vsr == '0) && !r_issue_valid && r_cap_valid) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy         = r_busy;
    assign done         = r_done;
    assign degree_in    = r_degree_in;
    assign x_in         = r_x_in;
    assign y_in         = r_y_in;
    assign sector_in    = r_sector_in;
    assign arctan_en_in = r_arctan_en;
    assign cap_valid    = r_cap_valid;
    assign cap_index    = r_cap_index;
    assign cap_degree   = r_cap_degree;
    assign cap_x        = r_cap_x;
    assign cap_y        = r_cap_y;

endmodule

// File: tb/tb_cordic_sweep_sequencer.sv
// Self-checking bench for cordic_sweep_sequencer: a fixed-latency stand-in pipeline plus
// a sweep reference model computed from start + k*step.
module tb_cordic_sweep_sequencer;

    localparam int W  = 16;
    localparam int SW = 2;
    localparam int L  = 7;
    localparam int CW = 12;

    logic          clk = 1'b0;
    logic          reset, start, mode;
    logic [W-1:0]  start_val, step, x_const, y_const;
    logic [CW-1:0] count;
    logic          busy, done, arctan_en_in, cap_valid;
    logic [W-1:0]  degree_in, x_in, y_in, degree_out, x_out, y_out;
    logic [W-1:0]  cap_degree, cap_x, cap_y;
    logic [SW-1:0] sector_in;
    logic [CW-1:0] cap_index;

    int checks = 0;
    int errors = 0;

    logic [W-1:0]  obs_deg[$];
    logic [W-1:0]  obs_y[$];
    logic [SW-1:0] obs_sec[$];

    always #5 clk = ~clk;

    cordic_sweep_sequencer #(.WIDTH(W), .SECTOR_FLAG_WIDTH(SW), .PIPE_LATENCY(L), .COUNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .start_val(start_val),
        .step(step), .count(count), .x_const(x_const), .y_const(y_const),
        .busy(busy), .done(done), .degree_in(degree_in), .x_in(x_in), .y_in(y_in),
        .sector_in(sector_in), .arctan_en_in(arctan_en_in), .degree_out(degree_out),
        .x_out(x_out), .y_out(y_out), .cap_valid(cap_valid), .cap_index(cap_index),
        .cap_degree(cap_degree), .cap_x(cap_x), .cap_y(cap_y)
    );

    // Stand-in pipeline: L register stages with a distinguishable transform per lane.
    logic [W-1:0] pd[L];
    logic [W-1:0] px[L];
    logic [W-1:0] py[L];
    always @(posedge clk) begin
        for (int i = L - 1; i > 0; i--) begin
            pd[i] <= pd[i-1];
            px[i] <= px[i-1];
            py[i] <= py[i-1];
        end
        pd[0] <= degree_in ^ 16'h5A5A;
        px[0] <= x_in + 16'd1;
        py[0] <= ~y_in;
    end
    assign degree_out = pd[L-1];
    assign x_out      = px[L-1];
    assign y_out      = py[L-1];

    // Reference: sample k of a sweep, from start + k*step modulo 2^W.
    function automatic void exp_sample(input logic m, input logic [W-1:0] sv, input logic [W-1:0] st,
                                       input logic [W-1:0] yc, input int k,
                                       output logic [W-1:0] deg, output logic [W-1:0] ys,
                                       output logic [SW-1:0] sec);
        logic [W-1:0] acc;
        acc = sv + st * W'(k);
        deg = m ? '0 : acc;
        ys  = m ? acc : yc;
        sec = m ? '0 : acc[W-1:W-2];
    endfunction

    task automatic randomize_inputs();
        mode      = 1'($urandom);
        start_val = W'($urandom);
        step      = W'($urandom);
        count     = CW'($urandom);
        x_const   = W'($urandom);
        y_const   = W'($urandom);
    endtask

    // Runs one sweep from IDLE and compares every cycle against the reference timeline.
    task automatic test_sweep(input logic m, input logic [W-1:0] sv, input logic [W-1:0] st,
                              input logic [CW-1:0] n, input logic [W-1:0] xc, input logic [W-1:0] yc,
                              input bit chaos);
        int nn;
        int kc;
        logic [W-1:0]  e_deg, e_y, c_deg, c_y;
        logic [SW-1:0] e_sec, c_sec;
        logic          e_busy, e_cv, e_done;
        nn = int'(n);
        obs_deg.delete();
        obs_y.delete();
        obs_sec.delete();
        @(negedge clk);
        mode = m; start_val = sv; step = st; count = n; x_const = xc; y_const = yc; start = 1'b1;
        @(posedge clk);
        for (int j = 0; j <= nn + L + 3; j++) begin
            @(negedge clk);
            if (nn > 0) begin
                exp_sample(m, sv, st, yc, (j < nn) ? j : nn - 1, e_deg, e_y, e_sec);
                if (j < nn) begin
                    obs_deg.push_back(degree_in);
                    obs_y.push_back(y_in);
                    obs_sec.push_back(sector_in);
                end
                checks++;
                if ({degree_in, x_in, y_in, sector_in, arctan_en_in} !== {e_deg, xc, e_y, e_sec, m}) begin
                    errors++;
                    $display("FAIL sample j=%0d got deg=%h x=%h y=%h sec=%0d at=%b want deg=%h x=%h y=%h sec=%0d at=%b",
                             j, degree_in, x_in, y_in, sector_in, arctan_en_in, e_deg, xc, e_y, e_sec, m);
                end
            end
            e_busy = (nn > 0) && (j <= nn + L);
            e_cv   = (nn > 0) && (j >= L + 1) && (j <= L + nn);
            e_done = (nn == 0) ? (j == 0) : (j == nn + L + 1);
            checks++;
            if ({busy, done, cap_valid} !== {e_busy, e_done, e_cv}) begin
                errors++;
                $display("FAIL flags j=%0d n=%0d got busy=%b done=%b cap_valid=%b want %b %b %b",
                         j, nn, busy, done, cap_valid, e_busy, e_done, e_cv);
            end
            if (e_cv) begin
                kc = j - L - 1;
                exp_sample(m, sv, st, yc, kc, c_deg, c_y, c_sec);
                checks++;
                if ({cap_index, cap_degree, cap_x, cap_y} !== {CW'(kc), c_deg ^ 16'h5A5A, xc + 16'd1, ~c_y}) begin
                    errors++;
                    $display("FAIL capture j=%0d got idx=%0d deg=%h x=%h y=%h want idx=%0d deg=%h x=%h y=%h",
                             j, cap_index, cap_degree, cap_x, cap_y, kc, c_deg ^ 16'h5A5A, xc + 16'd1, ~c_y);
                end
            end
            // Inputs and start are scrambled while the sweep is in flight; all must be ignored.
            if (chaos && nn > 0 && j <= nn + L) begin
                randomize_inputs();
                start = 1'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b1;
        randomize_inputs();
        count = 12'd5;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({busy, done, degree_in, x_in, y_in, sector_in, arctan_en_in,
                 cap_valid, cap_index, cap_degree, cap_x, cap_y} !== '0) begin
                errors++;
                $display("FAIL reset cycle=%0d busy=%b done=%b deg=%h x=%h y=%h sec=%0d at=%b cv=%b idx=%0d cd=%h cx=%h cy=%h",
                         i, busy, done, degree_in, x_in, y_in, sector_in, arctan_en_in,
                         cap_valid, cap_index, cap_degree, cap_x, cap_y);
            end
        end
        reset = 1'b1;
        start = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL reset_release got busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_rotate();
        logic [W-1:0] tab[4];
        tab = '{16'h0000, 16'h0010, 16'h0020, 16'h0030};
        test_sweep(1'b0, 16'h0000, 16'h0010, 12'd4, 16'h0100, 16'h01BB, 1'b1);
        checks++;
        if (obs_deg.size() != 4) begin
            errors++;
            $display("FAIL rotate_len got %0d want 4", obs_deg.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (obs_deg[i] !== tab[i]) begin
                    errors++;
                    $display("FAIL rotate_deg i=%0d got %h want %h", i, obs_deg[i], tab[i]);
                end
            end
        end
    endtask

    task automatic test_wrap_sector();
        logic [W-1:0]  tab_d[5];
        logic [SW-1:0] tab_s[5];
        tab_d = '{16'h0000, 16'h4000, 16'h8000, 16'hC000, 16'h0000};
        tab_s = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        test_sweep(1'b0, 16'h0000, 16'h4000, 12'd5, 16'h0100, 16'h0200, 1'b0);
        for (int i = 0; i < 5 && i < obs_deg.size(); i++) begin
            checks++;
            if ({obs_deg[i], obs_sec[i]} !== {tab_d[i], tab_s[i]}) begin
                errors++;
                $display("FAIL wrap i=%0d got deg=%h sec=%0d want deg=%h sec=%0d",
                         i, obs_deg[i], obs_sec[i], tab_d[i], tab_s[i]);
            end
        end
    endtask

    task automatic test_arctan();
        logic [W-1:0] tab[3];
        tab = '{16'h0100, 16'h0180, 16'h0200};
        test_sweep(1'b1, 16'h0100, 16'h0080, 12'd3, 16'h0100, 16'h7777, 1'b0);
        for (int i = 0; i < 3 && i < obs_y.size(); i++) begin
            checks++;
            if ({obs_y[i], obs_deg[i]} !== {tab[i], 16'h0000}) begin
                errors++;
                $display("FAIL arctan i=%0d got y=%h deg=%h want y=%h deg=0000", i, obs_y[i], obs_deg[i], tab[i]);
            end
        end
    endtask

    task automatic test_count_zero();
        test_sweep(1'b0, 16'h1234, 16'h0001, 12'd0, 16'h0100, 16'h0100, 1'b0);
    endtask

    task automatic test_random();
        for (int s = 0; s < 15; s++) begin
            test_sweep(1'($urandom), W'($urandom), W'($urandom), CW'($urandom_range(0, 12)),
                       W'($urandom), W'($urandom), 1'b1);
        end
    endtask

    task automatic test_back_to_back();
        int nn;
        int dones;
        logic [W-1:0]  e_deg, e_y;
        logic [SW-1:0] e_sec;
        nn = 3;
        @(negedge clk);
        mode = 1'b0; start_val = 16'h1000; step = 16'h0100; count = CW'(nn);
        x_const = 16'h0100; y_const = 16'h0200; start = 1'b1;
        @(posedge clk);
        for (int j = 0; j <= nn + L + 3; j++) begin
            @(negedge clk);
            if (j == 0) start_val = 16'h2000;
            if (j == nn + L + 1) begin
                checks++;
                if (done !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_done got %b want 1", done);
                end
            end
            if (j == nn + L + 2) begin
                exp_sample(1'b0, 16'h1000, 16'h0100, 16'h0200, nn - 1, e_deg, e_y, e_sec);
                checks++;
                if ({busy, done, degree_in} !== {2'b00, e_deg}) begin
                    errors++;
                    $display("FAIL b2b_gap got busy=%b done=%b deg=%h want 0 0 %h", busy, done, degree_in, e_deg);
                end
            end
            if (j == nn + L + 3) begin
                checks++;
                if ({busy, done, degree_in} !== {2'b10, 16'h2000}) begin
                    errors++;
                    $display("FAIL b2b_restart got busy=%b done=%b deg=%h want 1 0 2000", busy, done, degree_in);
                end
                start = 1'b0;
            end
        end
        dones = 0;
        for (int t = 0; t < 40 && dones == 0; t++) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        checks++;
        if (dones != 1) begin
            errors++;
            $display("FAIL b2b_second_done got %0d pulses within 40 cycles want 1", dones);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_abort();
        int n_cv, n_done, n_busy;
        @(negedge clk);
        mode = 1'b0; start_val = 16'h0500; step = 16'h0020; count = 12'd10;
        x_const = 16'h0100; y_const = 16'h0300; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (degree_in !== 16'h0520) begin
            errors++;
            $display("FAIL abort_second_sample got %h want 0520", degree_in);
        end
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        checks++;
        if ({busy, done, cap_valid, degree_in, cap_index} !== '0) begin
            errors++;
            $display("FAIL abort_clear got busy=%b done=%b cv=%b deg=%h idx=%0d want all 0",
                     busy, done, cap_valid, degree_in, cap_index);
        end
        n_cv = 0; n_done = 0; n_busy = 0;
        for (int t = 0; t < 25; t++) begin
            @(negedge clk);
            if (cap_valid === 1'b1) n_cv++;
            if (done === 1'b1)      n_done++;
            if (busy === 1'b1)      n_busy++;
        end
        checks++;
        if ({n_cv, n_done, n_busy} != '0) begin
            errors++;
            $display("FAIL abort_quiet got cap_valid=%0d done=%0d busy=%0d cycles want 0 0 0", n_cv, n_done, n_busy);
        end
    endtask

    initial begin
        test_reset();
        test_rotate();
        test_wrap_sector();
        test_arctan();
        test_count_zero();
        test_back_to_back();
        test_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout after 2 ms of simulated time");
        $fatal(1);
    end

endmodule
